ppi_bus_ctrl: RTL

Bus-side controller for the 8255-style PPI. It samples the host strobes (cs_n/rd_n/wr_n, a[1:0]) on clk and sequences each write into the mode-set or bit-set/reset (BSR) path. It holds the control word, the three port output latches and the per-port direction enables, and drives the host data bus on reads. It sits between the host bus and the port pad logic.

---
 rtl/ppi_pkg.sv | 30 +++
 rtl/ppi_cw_decode.sv | 19 +
 rtl/ppi_bus_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ppi_pkg.sv
// Shared constants, state encoding and control-word helpers for the 8255-style PPI bus controller.
package ppi_pkg;

    localparam logic [1:0] ADDR_PA = 2'b00;
    localparam logic [1:0] ADDR_PB = 2'b01;
    localparam logic [1:0] ADDR_PC = 2'b10;
    localparam logic [1:0] ADDR_CW = 2'b11;

    localparam int CW_MODESET = 7;
    localparam int CW_PA_DIR  = 4;
    localparam int CW_PCH_DIR = 3;
    localparam int CW_PB_DIR  = 1;
    localparam int CW_PCL_DIR = 0;

    localparam logic [7:0] CW_RESET_DEFAULT = 8'h9B;

    typedef enum logic [2:0] {
        IDLE,
        WR_LATCH,
        WR_APPLY,
        RD_DRIVE,
        WAIT_REL
    } state_t;

    // Only mode 0 is implemented: group A mode bits [6:5] and group B mode bit [2] must be clear.
    function automatic logic mode0_ok(input logic [7:0] cw);
        return cw[CW_MODESET] && (cw[6:5] == 2'b00) && !cw[2];
    endfunction

endpackage

// File: rtl/ppi_cw_decode.sv
// Control word to port/nibble output enables (a direction bit of 1 means input) plus mode-0 legality.
module ppi_cw_decode
    import ppi_pkg::*;
(
    input  logic [7:0] cw,
    output logic       pa_oe,
    output logic       pb_oe,
    output logic       pc_hi_oe,
    output logic       pc_lo_oe,
    output logic       mode_ok
);

    assign pa_oe    = !cw[CW_PA_DIR];
    assign pc_hi_oe = !cw[CW_PCH_DIR];
    assign pb_oe    = !cw[CW_PB_DIR];
    assign pc_lo_oe = !cw[CW_PCL_DIR];
    assign mode_ok  = mode0_ok(cw);

endmodule

// File: rtl/ppi_bus_ctrl.sv
// Host-bus side of the PPI: strobe edge detection, write sequencing (mode set / BSR / port latches)
// and registered read data. Define PPI_CW_READBACK_EN to make the control word readable at a=11.
module ppi_bus_ctrl
    import ppi_pkg::*;
#(
    parameter logic [7:0] CW_RESET = CW_RESET_DEFAULT,
    parameter logic [7:0] RD_FLOAT = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [1:0] a,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] pa_in,
    input  logic [7:0] pb_in,
    input  logic [7:0] pc_in,
    output logic [7:0] pa_out,
    output logic [7:0] pb_out,
    output logic [7:0] pc_out,
    output logic       pa_oe,
    output logic       pb_oe,
    output logic       pc_hi_oe,
    output logic       pc_lo_oe,
    output logic       busy,
    output logic       mode_err
);

    state_t     state_reg;
    logic       wr_n_reg, rd_n_reg;
    logic [7:0] cw_reg, pa_reg, pb_reg, pc_reg;
    logic [7:0] hold_d_reg;
    logic [1:0] hold_a_reg;
    logic [7:0] d_out_reg;
    logic       d_oe_reg, mode_err_reg;

    logic       wr_fall, rd_fall, cw_mode_ok;
    logic [1:0] pc_nib_oe;
    logic [7:0] pc_rd, rd_val;

    ppi_cw_decode u_cw_decode (
        .cw       (cw_reg),
        .pa_oe    (pa_oe),
        .pb_oe    (pb_oe),
        .pc_hi_oe (pc_hi_oe),
        .pc_lo_oe (pc_lo_oe),
        .mode_ok  (cw_mode_ok)
    );

    assign wr_fall = !cs_n && wr_n_reg && !wr_n;
    assign rd_fall = !cs_n && rd_n_reg && !rd_n;

    // Port C nibbles are read back independently: latch when driven, pins when input.
    assign pc_nib_oe = {pc_hi_oe, pc_lo_oe};
    for (genvar gi = 0; gi < 2; gi++) begin : g_pc_nib
        assign pc_rd[gi*4 +: 4] = pc_nib_oe[gi] ? pc_reg[gi*4 +: 4] : pc_in[gi*4 +: 4];
    end

    always_comb begin
        rd_val = 8'h00;
        case (a)
            ADDR_PA: rd_val = pa_oe ? pa_reg : pa_in;
            ADDR_PB: rd_val = pb_oe ? pb_reg : pb_in;
            ADDR_PC: rd_val = pc_rd;
            default: begin
`ifdef PPI_CW_READBACK_EN
                rd_val = cw_reg;
`else
                rd_val = RD_FLOAT;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_n_reg     <= 1'b1;
            rd_n_reg     <= 1'b1;
            cw_reg       <= CW_RESET;
            pa_reg       <= 8'h00;
            pb_reg       <= 8'h00;
            pc_reg       <= 8'h00;
            hold_d_reg   <= 8'h00;
            hold_a_reg   <= 2'b00;
            d_out_reg    <= 8'h00;
            d_oe_reg     <= 1'b0;
            mode_err_reg <= 1'b0;
        end else begin
            wr_n_reg <= wr_n;
            rd_n_reg <= rd_n;
            if (!cw_mode_ok)
                mode_err_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    // Simultaneous strobes are an illegal access: park until both release.
                    if ((wr_fall || rd_fall) && !wr_n && !rd_n) begin
                        state_reg <= WAIT_REL;
                    end else if (wr_fall) begin
                        state_reg <= WR_LATCH;
                    end else if (rd_fall) begin
                        state_reg <= RD_DRIVE;
                        d_oe_reg  <= 1'b1;
                        d_out_reg <= rd_val;
                    end
                end
                WR_LATCH: begin
                    hold_d_reg <= d_in;
                    hold_a_reg <= a;
                    state_reg  <= WR_APPLY;
                end
                WR_APPLY: begin
                    case (hold_a_reg)
                        ADDR_PA: pa_reg <= hold_d_reg;
                        ADDR_PB: pb_reg <= hold_d_reg;
                        ADDR_PC: pc_reg <= hold_d_reg;
                        default: begin
                            if (hold_d_reg[CW_MODESET]) begin
                                cw_reg <= hold_d_reg;
                                pa_reg <= 8'h00;
                                pb_reg <= 8'h00;
                                pc_reg <= 8'h00;
                                if (!mode0_ok(hold_d_reg))
                                    mode_err_reg <= 1'b1;
                            end else begin
                                pc_reg[hold_d_reg[3:1]] <= hold_d_reg[0];
                            end
                        end
                    endcase
                    state_reg <= WAIT_REL;
                end
                RD_DRIVE: begin
                    if (rd_n || cs_n) begin
                        state_reg <= IDLE;
                        d_oe_reg  <= 1'b0;
                    end else begin
                        d_out_reg <= rd_val;
                    end
                end
                WAIT_REL: begin
                    if ((wr_n && rd_n) || cs_n)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign d_out    = d_out_reg;
    assign d_oe     = d_oe_reg;
    assign pa_out   = pa_reg;
    assign pb_out   = pb_reg;
    assign pc_out   = pc_reg;
    assign busy     = (state_reg != IDLE);
    assign mode_err = mode_err_reg;

endmodule
